// File: rtl/draw_manager_if.sv
// Draw-source write bus shared by starfield, sprite and HUD units.
// slave: the draw manager (owns source selection, consumes pixels).
// master: a draw source (drives the pixel stream while selected).
interface draw_manager_if #(
  parameter int unsigned SOURCES_COUNT = 4,
  parameter int unsigned COLOR_DEPTH   = 9
) ();

  localparam int unsigned SelW = (SOURCES_COUNT > 1) ? $clog2(SOURCES_COUNT) : 1;

  logic [SelW-1:0]        write_source_sel;
  logic                   write_awaited;
  logic                   write_active;
  logic [COLOR_DEPTH-1:0] write_color_data;
  logic                   write_transparent;
  logic [31:0]            write_x_addr;
  logic [31:0]            write_y_addr;

  modport master (
    input  write_source_sel,
    input  write_awaited,
    output write_active,
    output write_color_data,
    output write_transparent,
    output write_x_addr,
    output write_y_addr
  );

  modport slave (
    output write_source_sel,
    output write_awaited,
    input  write_active,
    input  write_color_data,
    input  write_transparent,
    input  write_x_addr,
    input  write_y_addr
  );

endinterface

// File: rtl/draw_manager.sv
// Per-frame draw sequencer: grants the shared write bus to each source in turn and turns
// accepted pixels into registered framebuffer writes (1-cycle latency, no backpressure).
// Optional background clear before the sources is enabled by defining DRAW_MGR_CLEAR_EN.
module draw_manager #(
  parameter int unsigned           SOURCES_COUNT = 4,
  parameter int unsigned           COLOR_DEPTH   = 9,
  parameter int unsigned           FB_WIDTH      = 640,
  parameter int unsigned           FB_HEIGHT     = 480,
  parameter int unsigned           AWAIT_TIMEOUT = 4096,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR     = '0,
  localparam int unsigned          AddrW = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_i,
  draw_manager_if.slave          bus,
  output logic                   fb_wr_en_o,
  output logic [AddrW-1:0]       fb_wr_addr_o,
  output logic [COLOR_DEPTH-1:0] fb_wr_data_o,
  output logic                   draw_done_o,
  output logic                   frame_overrun_o
);

  localparam int unsigned SelW = (SOURCES_COUNT > 1) ? $clog2(SOURCES_COUNT) : 1;
  localparam int unsigned TmoW = (AWAIT_TIMEOUT > 1) ? $clog2(AWAIT_TIMEOUT) : 1;
  localparam logic [SelW-1:0] LastSel = SelW'(SOURCES_COUNT - 1);
  localparam logic [TmoW-1:0] LastTmo = TmoW'(AWAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
`ifdef DRAW_MGR_CLEAR_EN
    StClear,
`endif
    StAwait,
    StStream,
    StNext,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic                   fb_en_q, fb_en_d;
  logic [AddrW-1:0]       fb_addr_q, fb_addr_d;
  logic [COLOR_DEPTH-1:0] fb_data_q, fb_data_d;
  logic                   ovr_q, ovr_d;
  logic                   accept;
  logic                   x_ok, y_ok;
`ifdef DRAW_MGR_CLEAR_EN
  localparam logic [AddrW-1:0] LastClr = AddrW'(FB_WIDTH * FB_HEIGHT - 1);
  logic [AddrW-1:0]       clr_q, clr_d;
`endif

  // Pixel acceptance: bus only sampled while the selected source owns it.
  always_comb begin
    // Sign bit set means negative; otherwise an unsigned compare is the signed one.
    x_ok   = !bus.write_x_addr[31] && (bus.write_x_addr < FB_WIDTH);
    y_ok   = !bus.write_y_addr[31] && (bus.write_y_addr < FB_HEIGHT);
    accept = ((state_q == StAwait) || (state_q == StStream)) && bus.write_active &&
             !bus.write_transparent && x_ok && y_ok;
  end

  // Frame sequencing: next state, source select, timeout and clear counters.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
`ifdef DRAW_MGR_CLEAR_EN
    clr_d   = clr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (frame_i) begin
          sel_d = '0;
          tmo_d = '0;
`ifdef DRAW_MGR_CLEAR_EN
          clr_d   = '0;
          state_d = StClear;
`else
          state_d = StAwait;
`endif
        end
      end
`ifdef DRAW_MGR_CLEAR_EN
      StClear: begin
        if (clr_q == LastClr) begin
          sel_d   = '0;
          tmo_d   = '0;
          state_d = StAwait;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
`endif
      StAwait: begin
        if (bus.write_active) begin
          state_d = StStream;
        end else if (tmo_q == LastTmo) begin
          state_d = StNext;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StStream: begin
        if (!bus.write_active) state_d = StNext;
      end
      StNext: begin
        if (sel_q < LastSel) begin
          sel_d   = sel_q + 1'b1;
          tmo_d   = '0;
          state_d = StAwait;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        sel_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Framebuffer write pipeline and overrun detection.
  always_comb begin
    fb_en_d   = accept;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (accept) begin
      // Operands already range-checked, so truncating to AddrW cannot alias.
      fb_addr_d = bus.write_y_addr[AddrW-1:0] * AddrW'(FB_WIDTH) + bus.write_x_addr[AddrW-1:0];
      fb_data_d = bus.write_color_data;
    end
`ifdef DRAW_MGR_CLEAR_EN
    if (state_q == StClear) begin
      fb_en_d   = 1'b1;
      fb_addr_d = clr_q;
      fb_data_d = BG_COLOR;
    end
`endif
    ovr_d = frame_i && (state_q != StIdle);
  end

  // State and pipeline registers; reset wins over everything and drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      tmo_q     <= '0;
      fb_en_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      ovr_q     <= 1'b0;
`ifdef DRAW_MGR_CLEAR_EN
      clr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      fb_en_q   <= fb_en_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      ovr_q     <= ovr_d;
`ifdef DRAW_MGR_CLEAR_EN
      clr_q     <= clr_d;
`endif
    end
  end

  assign bus.write_source_sel = sel_q;
  assign bus.write_awaited    = (state_q == StAwait);
  assign fb_wr_en_o           = fb_en_q;
  assign fb_wr_addr_o         = fb_addr_q;
  assign fb_wr_data_o         = fb_data_q;
  assign draw_done_o          = (state_q == StDone);
  assign frame_overrun_o      = ovr_q;

endmodule

// File: tb/tb_draw_manager.sv
// Self-checking bench for draw_manager: directed frames plus randomized pixel streams,
// checked against a frame-level reference model of the source schedule and pixel rules.
// Define DRAW_MGR_CLEAR_EN to exercise the background clear on an 8x4 framebuffer.
`timescale 1ns / 1ps
module tb_draw_manager;

  localparam int NSrc = 4;
  localparam int CD   = 9;
`ifdef DRAW_MGR_CLEAR_EN
  localparam int W    = 8;
  localparam int H    = 4;
`else
  localparam int W    = 640;
  localparam int H    = 480;
`endif
  localparam int T    = 64;
  localparam int AW   = $clog2(W * H);
  localparam logic [CD-1:0] BG = 9'h0A5;

  typedef struct packed {
    logic [31:0]   x;
    logic [31:0]   y;
    logic [CD-1:0] c;
    logic          t;
  } pix_t;

  logic          clk;
  logic          rst;
  logic          frame_i;
  logic          fb_wr_en;
  logic [AW-1:0] fb_wr_addr;
  logic [CD-1:0] fb_wr_data;
  logic          draw_done;
  logic          frame_overrun;

  draw_manager_if #(.SOURCES_COUNT(NSrc), .COLOR_DEPTH(CD)) bus ();

  draw_manager #(
    .SOURCES_COUNT(NSrc),
    .COLOR_DEPTH  (CD),
    .FB_WIDTH     (W),
    .FB_HEIGHT    (H),
    .AWAIT_TIMEOUT(T),
    .BG_COLOR     (BG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_i        (frame_i),
    .bus            (bus),
    .fb_wr_en_o     (fb_wr_en),
    .fb_wr_addr_o   (fb_wr_addr),
    .fb_wr_data_o   (fb_wr_data),
    .draw_done_o    (draw_done),
    .frame_overrun_o(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expectations for the outputs seen at the next sampling point.
  logic          exp_en, exp_ovr, exp_done;
  logic [AW-1:0] exp_addr;
  logic [CD-1:0] exp_data;

  // Frame plan: pixel lists per source (empty list = silent source), AWAIT delays.
  pix_t        pq[$];
  int          cnt[NSrc];
  int          dly[NSrc];
  int unsigned ovr_prob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit model_ok(input pix_t p);
    int sx, sy;
    sx = p.x;
    sy = p.y;
    return !p.t && sx >= 0 && sx < W && sy >= 0 && sy < H;
  endfunction

  function automatic logic [31:0] rnd_coord(input int lim);
    case ($urandom_range(9))
      0: return 32'(-int'($urandom_range(4, 1)));
      1: return 32'(lim + int'($urandom_range(3)));
      2: return 32'h8000_0000 | 32'($urandom_range(1000));
      3: return 32'h0001_0000 + 32'($urandom_range(7));
      4: return 32'(lim - 1);
      5: return 32'd0;
      default: return 32'($urandom_range(lim - 1));
    endcase
  endfunction

  function automatic pix_t rnd_pix();
    pix_t p;
    p.x = rnd_coord(W);
    p.y = rnd_coord(H);
    p.c = CD'($urandom);
    p.t = ($urandom_range(3) == 0);
    return p;
  endfunction

  task automatic set_bus(input logic act, input pix_t p);
    bus.write_active      = act;
    bus.write_x_addr      = p.x;
    bus.write_y_addr      = p.y;
    bus.write_color_data  = p.c;
    bus.write_transparent = p.t;
  endtask

  task automatic drive_pixel(input pix_t p);
    int lin;
    set_bus(1'b1, p);
    if (model_ok(p)) begin
      lin      = int'(p.y) * W + int'(p.x);
      exp_en   = 1'b1;
      exp_addr = AW'(lin);
      exp_data = p.c;
    end
  endtask

  task automatic maybe_frame();
    if ($urandom_range(99) < ovr_prob) begin
      frame_i = 1'b1;
      exp_ovr = 1'b1;
    end
  endtask

  // One clock: inputs set before the edge, outputs checked on the falling edge after it.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("fb_wr_en", 32'(fb_wr_en), 32'(exp_en));
    if (exp_en) begin
      chk("fb_wr_addr", 32'(fb_wr_addr), 32'(exp_addr));
      chk("fb_wr_data", 32'(fb_wr_data), 32'(exp_data));
    end
    chk("frame_overrun", 32'(frame_overrun), 32'(exp_ovr));
    chk("draw_done", 32'(draw_done), 32'(exp_done));
    exp_en   = 1'b0;
    exp_ovr  = 1'b0;
    exp_done = 1'b0;
    frame_i  = 1'b0;
  endtask

  task automatic chk_bus(input string tag, input logic aw, input int sel);
    chk({tag, "_awaited"}, 32'(bus.write_awaited), 32'(aw));
    chk({tag, "_sel"}, 32'(bus.write_source_sel), 32'(sel));
  endtask

  // Plays one frame from IDLE; rst_src >= 0 resets the DUT in that source's stream.
  task automatic run_frame(input int rst_src);
    int   qi;
    pix_t p;
    qi      = 0;
    frame_i = 1'b1;
    set_bus(1'b1, rnd_pix());
    tick();
`ifdef DRAW_MGR_CLEAR_EN
    for (int i = 0; i < W * H; i++) begin
      chk("clear_awaited", 32'(bus.write_awaited), 32'd0);
      exp_en   = 1'b1;
      exp_addr = AW'(i);
      exp_data = BG;
      maybe_frame();
      set_bus(1'b1, rnd_pix());
      tick();
    end
`endif
    for (int s = 0; s < NSrc; s++) begin
      chk_bus("await_entry", 1'b1, s);
      if (cnt[s] == 0) begin
        for (int k = 1; k < T; k++) begin
          maybe_frame();
          set_bus(1'b0, rnd_pix());
          tick();
          chk_bus("await_wait", 1'b1, s);
        end
        maybe_frame();
        set_bus(1'b0, rnd_pix());
        tick();
        chk_bus("timeout_next", 1'b0, s);
      end else begin
        for (int d = 0; d < dly[s]; d++) begin
          maybe_frame();
          set_bus(1'b0, rnd_pix());
          tick();
          chk_bus("await_delay", 1'b1, s);
        end
        for (int j = 0; j < cnt[s]; j++) begin
          maybe_frame();
          drive_pixel(pq[qi]);
          qi++;
          tick();
          chk_bus("stream", 1'b0, s);
          if (s == rst_src) begin
            p.x = 32'd1;
            p.y = 32'd1;
            p.c = CD'($urandom);
            p.t = 1'b0;
            set_bus(1'b1, p);
            rst = 1'b1;
            tick();
            chk_bus("rst_mid", 1'b0, 0);
            rst = 1'b0;
            set_bus(1'b1, rnd_pix());
            tick();
            chk_bus("rst_idle", 1'b0, 0);
            return;
          end
        end
        maybe_frame();
        set_bus(1'b0, rnd_pix());
        tick();
        chk_bus("stream_end", 1'b0, s);
      end
      // NEXT: bus is not sampled here even with active asserted.
      maybe_frame();
      set_bus(1'b1, rnd_pix());
      if (s == NSrc - 1) exp_done = 1'b1;
      tick();
    end
    maybe_frame();
    set_bus(1'b1, rnd_pix());
    tick();
    chk_bus("idle_after_done", 1'b0, 0);
    set_bus(1'b1, rnd_pix());
    tick();
    chk_bus("idle_hold", 1'b0, 0);
  endtask

  task automatic gen_frame(input bit all_active);
    pq.delete();
    for (int s = 0; s < NSrc; s++) begin
      cnt[s] = (!all_active && $urandom_range(4) == 0) ? 0 : int'($urandom_range(6, 1));
      dly[s] = int'($urandom_range(5));
      for (int j = 0; j < cnt[s]; j++) pq.push_back(rnd_pix());
    end
  endtask

  function automatic pix_t mk(input int x, input int y, input logic [CD-1:0] c, input logic t);
    pix_t p;
    p.x = 32'(x);
    p.y = 32'(y);
    p.c = c;
    p.t = t;
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_en   = 1'b0;
    exp_ovr  = 1'b0;
    exp_done = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    frame_i  = 1'b0;
    ovr_prob = 0;
    rst      = 1'b1;
    set_bus(1'b1, mk(3, 3, 9'h155, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bus("reset", 1'b0, 0);
    chk("reset_fb_en", 32'(fb_wr_en), 32'd0);
    chk("reset_fb_addr", 32'(fb_wr_addr), 32'd0);
    chk("reset_fb_data", 32'(fb_wr_data), 32'd0);
    chk("reset_done", 32'(draw_done), 32'd0);
    chk("reset_ovr", 32'(frame_overrun), 32'd0);
    rst = 1'b0;
    set_bus(1'b0, rnd_pix());
    tick();

    // Single-source stream; sources 1..3 stay silent and time out.
    pq.delete();
    pq.push_back(mk(0, 0, 9'h1FF, 1'b0));
    pq.push_back(mk(W - 1, H - 1, 9'h1FF, 1'b0));
    pq.push_back(mk(10, 2, 9'h1FF, 1'b0));
    cnt = '{3, 0, 0, 0};
    dly = '{0, 0, 0, 0};
    run_frame(-1);

    // Rejection: every pixel of source 0 is dropped, later sources still write.
    pq.delete();
    pq.push_back(mk(-1, 5, 9'h011, 1'b0));
    pq.push_back(mk(W, 0, 9'h022, 1'b0));
    pq.push_back(mk(5, H, 9'h033, 1'b0));
    pq.push_back(mk(5, 3, 9'h044, 1'b1));
    pq.push_back(mk(1, 2, 9'h0F0, 1'b0));
    pq.push_back(mk(W - 2, 0, 9'h10F, 1'b0));
    cnt = '{4, 1, 1, 0};
    dly = '{1, 0, 2, 0};
    run_frame(-1);

    // Frame pulses on every busy cycle: all flagged as overruns, sequence unaffected.
    gen_frame(1'b1);
    ovr_prob = 100;
    run_frame(-1);
    ovr_prob = 0;
    gen_frame(1'b0);
    run_frame(-1);

    // Randomized frames with occasional overruns.
    ovr_prob = 15;
    for (int f = 0; f < 12; f++) begin
      gen_frame(1'b0);
      run_frame(-1);
    end
    ovr_prob = 0;

    // Reset in the middle of source 2's stream, then a clean frame.
    gen_frame(1'b1);
    run_frame(2);
    gen_frame(1'b0);
    run_frame(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
